// File: rtl/nbit_down_timer_pkg.sv
// Shared types for the n-bit down timer.
package nbit_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } timer_state_t;

endpackage

// File: rtl/nbit_down_timer_if.sv
// Control/status bundle for the n-bit down timer; clock and reset stay outside.
interface nbit_down_timer_if #(parameter int SIZE = 8);

  logic            CE;
  logic            LOAD;
  logic [SIZE-1:0] LOAD_VAL;
  logic            START;
  logic            STOP;
  logic [SIZE-1:0] DOUT;
  logic            TC;
  logic            BUSY;

  modport master (
    output CE, LOAD, LOAD_VAL, START, STOP,
    input  DOUT, TC, BUSY
  );

  modport slave (
    input  CE, LOAD, LOAD_VAL, START, STOP,
    output DOUT, TC, BUSY
  );

endinterface

// File: rtl/nbit_down_timer.sv
// Loadable down-counter/timer with one-cycle terminal-count pulse.
// Define NBIT_DOWN_TIMER_AUTO_RELOAD_EN for periodic (auto-reload) operation.
module nbit_down_timer
  import nbit_timer_pkg::*;
#(
  parameter int SIZE = 8
) (
  input  logic               CLK,
  input  logic               RST_N,
  nbit_down_timer_if.slave   bus
);

  localparam logic [SIZE-1:0] ONE  = SIZE'(1);
  localparam logic [SIZE-1:0] ZERO = '0;

  timer_state_t    state, state_next;
  logic [SIZE-1:0] dout_q, dout_next;
  logic [SIZE-1:0] reload_q, reload_next;
  logic            tc_q, tc_next;
  logic            busy_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      dout_q   <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_next;
      dout_q   <= dout_next;
      reload_q <= reload_next;
      tc_q     <= tc_next;
      busy_q   <= (state_next == RUN);
    end
  end

  // Strobes resolve in the order LOAD, STOP, START, then counting.
  always_comb begin
    state_next  = state;
    dout_next   = dout_q;
    reload_next = reload_q;
    tc_next     = 1'b0;

    if (bus.LOAD) begin
      dout_next   = bus.LOAD_VAL;
      reload_next = bus.LOAD_VAL;
      state_next  = IDLE;
    end else if (bus.STOP) begin
      if (state == RUN) begin
        state_next = IDLE;
      end
    end else if (bus.START && (state != RUN)) begin
      if (state == IDLE) begin
        if (dout_q != ZERO) begin
          state_next = RUN;
        end else begin
          state_next = DONE;
          tc_next    = 1'b1;
        end
      end else if (reload_q != ZERO) begin
        dout_next  = reload_q;
        state_next = RUN;
      end else begin
        tc_next = 1'b1;
      end
    end else if ((state == RUN) && bus.CE) begin
      if (dout_q > ONE) begin
        dout_next = dout_q - ONE;
      end else if (dout_q == ONE) begin
        tc_next = 1'b1;
`ifdef NBIT_DOWN_TIMER_AUTO_RELOAD_EN
        dout_next = reload_q;
`else
        dout_next  = ZERO;
        state_next = DONE;
`endif
      end
    end
  end

  assign bus.DOUT = dout_q;
  assign bus.TC   = tc_q;
  assign bus.BUSY = busy_q;

endmodule

// File: tb/tb_nbit_down_timer.sv
// Scoreboard bench for nbit_down_timer; also exercises NBIT_DOWN_TIMER_AUTO_RELOAD_EN when defined.
module tb_nbit_down_timer;

  localparam int SIZE = 8;

  typedef struct {
    logic [SIZE-1:0] dout;
    logic            tc;
    logic            busy;
  } exp_t;

  logic CLK;
  logic RST_N;
  int   checks;
  int   errors;
  exp_t sb[$];

  // Reference model state: 0 idle, 1 run, 2 done
  int              mState;
  logic [SIZE-1:0] mDout;
  logic [SIZE-1:0] mReload;
  logic            mTc;

  nbit_down_timer_if #(.SIZE(SIZE)) bus ();

  nbit_down_timer #(.SIZE(SIZE)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic modelReset();
    mState  = 0;
    mDout   = '0;
    mReload = '0;
    mTc     = 1'b0;
    sb.delete();
  endtask

  // Advances the model by one edge using the inputs currently driven.
  task automatic modelEdge();
    exp_t e;
    mTc = 1'b0;
    if (bus.LOAD) begin
      mDout   = bus.LOAD_VAL;
      mReload = bus.LOAD_VAL;
      mState  = 0;
    end else if (bus.STOP) begin
      if (mState == 1) mState = 0;
    end else if (bus.START && mState == 0) begin
      if (mDout != 0) mState = 1;
      else begin mState = 2; mTc = 1'b1; end
    end else if (bus.START && mState == 2) begin
      if (mReload != 0) begin mDout = mReload; mState = 1; end
      else mTc = 1'b1;
    end else if (mState == 1 && bus.CE) begin
      if (mDout > 1) mDout = mDout - 1;
      else if (mDout == 1) begin
        mTc = 1'b1;
`ifdef NBIT_DOWN_TIMER_AUTO_RELOAD_EN
        mDout = mReload;
`else
        mDout  = '0;
        mState = 2;
`endif
      end
    end
    e.dout = mDout;
    e.tc   = mTc;
    e.busy = (mState == 1);
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input logic ce, input logic load, input logic [SIZE-1:0] val,
                               input logic start, input logic stop);
    bus.CE       = ce;
    bus.LOAD     = load;
    bus.LOAD_VAL = val;
    bus.START    = start;
    bus.STOP     = stop;
  endtask

  task automatic tick();
    modelEdge();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    checks++;
    if (bus.DOUT !== 8'd0 || bus.TC !== 1'b0 || bus.BUSY !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_initial: dout=%0d tc=%0b busy=%0b, expected 0/0/0", bus.DOUT, bus.TC, bus.BUSY);
    end
    @(posedge CLK); #1;
    RST_N = 1'b1;
    modelReset();
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, i == 0, 8'd20, i == 1, 1'b0);
      tick();
      e = sb.pop_front();
      checks++;
      if (bus.DOUT !== e.dout || bus.TC !== e.tc || bus.BUSY !== e.busy) begin
        errors++;
        $display("[TB] FAIL reset_count cyc %0d: dout=%0d tc=%0b busy=%0b, expected %0d/%0b/%0b",
                 i, bus.DOUT, bus.TC, bus.BUSY, e.dout, e.tc, e.busy);
      end
    end
    #2 RST_N = 1'b0;
    #1;
    checks++;
    if (bus.DOUT !== 8'd0 || bus.TC !== 1'b0 || bus.BUSY !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_async: dout=%0d tc=%0b busy=%0b, expected 0/0/0", bus.DOUT, bus.TC, bus.BUSY);
    end
    applyStimulus(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    modelReset();
  endtask

  task automatic test_one_shot();
    exp_t e;
    int   tcCount;
    tcCount = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, i == 0, 8'd5, i == 1, 1'b0);
      tick();
      e = sb.pop_front();
      if (bus.TC === 1'b1) tcCount++;
      checks++;
      if (bus.DOUT !== e.dout || bus.TC !== e.tc || bus.BUSY !== e.busy) begin
        errors++;
        $display("[TB] FAIL one_shot cyc %0d: dout=%0d tc=%0b busy=%0b, expected %0d/%0b/%0b",
                 i, bus.DOUT, bus.TC, bus.BUSY, e.dout, e.tc, e.busy);
      end
    end
`ifndef NBIT_DOWN_TIMER_AUTO_RELOAD_EN
    checks++;
    if (tcCount != 1 || bus.DOUT !== 8'd0) begin
      errors++;
      $display("[TB] FAIL one_shot_end: tc pulses=%0d dout=%0d, expected 1 pulse and dout 0", tcCount, bus.DOUT);
    end
`endif
  endtask

  task automatic test_pause_ce();
    exp_t e;
    int   tcFirst;
    logic ce, start;
    tcFirst = -1;
    for (int i = 0; i < 28; i++) begin
      ce    = (i < 10) ? 1'b1 : logic'((i - 10) % 2);
      start = (i == 1) || (i == 10);
      applyStimulus(ce, i == 0, 8'd10, start, i == 5);
      tick();
      e = sb.pop_front();
      if (bus.TC === 1'b1 && tcFirst < 0) tcFirst = i;
      checks++;
      if (bus.DOUT !== e.dout || bus.TC !== e.tc || bus.BUSY !== e.busy) begin
        errors++;
        $display("[TB] FAIL pause_ce cyc %0d: dout=%0d tc=%0b busy=%0b, expected %0d/%0b/%0b",
                 i, bus.DOUT, bus.TC, bus.BUSY, e.dout, e.tc, e.busy);
      end
      if (i == 9) begin
        checks++;
        if (bus.DOUT !== 8'd7 || bus.BUSY !== 1'b0) begin
          errors++;
          $display("[TB] FAIL pause_hold: dout=%0d busy=%0b, expected 7/0", bus.DOUT, bus.BUSY);
        end
      end
    end
    checks++;
    if (tcFirst - 10 + 1 != 14) begin
      errors++;
      $display("[TB] FAIL resume_tc_latency: %0d cycles, expected 14", tcFirst - 10 + 1);
    end
  endtask

  task automatic test_priority();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, (i == 0) || (i == 3), (i == 3) ? 8'd9 : 8'd3, (i == 0) || (i == 1), 1'b0);
      tick();
      e = sb.pop_front();
      checks++;
      if (bus.DOUT !== e.dout || bus.TC !== e.tc || bus.BUSY !== e.busy) begin
        errors++;
        $display("[TB] FAIL priority cyc %0d: dout=%0d tc=%0b busy=%0b, expected %0d/%0b/%0b",
                 i, bus.DOUT, bus.TC, bus.BUSY, e.dout, e.tc, e.busy);
      end
      if (i == 0 || i == 3) begin
        checks++;
        if (bus.DOUT !== ((i == 0) ? 8'd3 : 8'd9) || bus.BUSY !== 1'b0 || bus.TC !== 1'b0) begin
          errors++;
          $display("[TB] FAIL load_wins cyc %0d: dout=%0d busy=%0b tc=%0b", i, bus.DOUT, bus.BUSY, bus.TC);
        end
      end
    end
  endtask

  task automatic test_zero();
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, i == 0, 8'd0, (i == 1) || (i == 3), 1'b0);
      tick();
      e = sb.pop_front();
      checks++;
      if (bus.DOUT !== e.dout || bus.TC !== e.tc || bus.BUSY !== e.busy) begin
        errors++;
        $display("[TB] FAIL zero cyc %0d: dout=%0d tc=%0b busy=%0b, expected %0d/%0b/%0b",
                 i, bus.DOUT, bus.TC, bus.BUSY, e.dout, e.tc, e.busy);
      end
      checks++;
      if (bus.TC !== logic'((i == 1) || (i == 3)) || bus.DOUT !== 8'd0) begin
        errors++;
        $display("[TB] FAIL zero_tc cyc %0d: tc=%0b dout=%0d", i, bus.TC, bus.DOUT);
      end
    end
  endtask

`ifdef NBIT_DOWN_TIMER_AUTO_RELOAD_EN
  task automatic test_auto_reload();
    exp_t e;
    int   tcCount;
    int   busyLow;
    tcCount = 0;
    busyLow = 0;
    for (int i = 0; i < 22; i++) begin
      applyStimulus(1'b1, i == 0, 8'd4, i == 1, 1'b0);
      tick();
      e = sb.pop_front();
      if (i >= 2 && bus.TC === 1'b1) tcCount++;
      if (i >= 1 && bus.BUSY !== 1'b1) busyLow++;
      checks++;
      if (bus.DOUT !== e.dout || bus.TC !== e.tc || bus.BUSY !== e.busy) begin
        errors++;
        $display("[TB] FAIL auto_reload cyc %0d: dout=%0d tc=%0b busy=%0b, expected %0d/%0b/%0b",
                 i, bus.DOUT, bus.TC, bus.BUSY, e.dout, e.tc, e.busy);
      end
    end
    checks++;
    if (tcCount != 5 || busyLow != 0) begin
      errors++;
      $display("[TB] FAIL auto_reload_pulses: tc=%0d busy_low=%0d, expected 5/0", tcCount, busyLow);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    RST_N  = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    modelReset();
    #12;
    test_reset();
    test_one_shot();
    test_pause_ce();
    test_priority();
    test_zero();
`ifdef NBIT_DOWN_TIMER_AUTO_RELOAD_EN
    test_auto_reload();
`endif
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
